// File: rtl/imba_menu_controller.sv
// ============================================================================
// Module   : imba_menu_controller
// Purpose  : Clap/button driven menu state feeding the overlay renderer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module imba_menu_controller #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd540_000_000
) (
    input  logic       CLK_VGA,
    input  logic       RST_N,
    input  logic       clap_pulse,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_select,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic       Menu_Clap,
    output logic [1:0] menu_state,
    output logic [2:0] cursor,
    output logic [1:0] LIRO_state,
    output logic [1:0] wave_sel,
    output logic       axis_en,
    output logic       grid_en,
    output logic       ticks_en,
    output logic       fft_en,
    output logic       amp_en
);

    typedef enum logic [1:0] {
        PG_MAIN = 2'd0,
        PG_WAVE = 2'd1,
        PG_DISP = 2'd2,
        PG_ANAL = 2'd3
    } page_e;

    localparam int BI_UP = 0, BI_DOWN = 1, BI_SEL = 2, BI_LEFT = 3, BI_RIGHT = 4;

    logic        open_q,  open_d;
    page_e       page_q,  page_d;
    logic [2:0]  cursor_q, cursor_d;
    logic [1:0]  liro_q,  liro_d;
    logic [1:0]  wave_q,  wave_d;
    logic        axis_q,  axis_d;
    logic        grid_q,  grid_d;
    logic        ticks_q, ticks_d;
    logic        fft_q,   fft_d;
    logic        amp_q,   amp_d;
    logic [4:0]  btn_q,   btn_d;
    logic [31:0] idle_q,  idle_d;

    logic [4:0]  btn_now;
    logic [4:0]  ev;
    logic [2:0]  last_idx;
    logic        timeout_hit;

    always_ff @(posedge CLK_VGA or negedge RST_N) begin
        if (!RST_N) begin
            open_q   <= 1'b0;
            page_q   <= PG_MAIN;
            cursor_q <= 3'd0;
            liro_q   <= 2'd0;
            wave_q   <= 2'd0;
            axis_q   <= 1'b1;
            grid_q   <= 1'b0;
            ticks_q  <= 1'b1;
            fft_q    <= 1'b0;
            amp_q    <= 1'b0;
            btn_q    <= 5'd0;
            idle_q   <= 32'd0;
        end else begin
            open_q   <= open_d;
            page_q   <= page_d;
            cursor_q <= cursor_d;
            liro_q   <= liro_d;
            wave_q   <= wave_d;
            axis_q   <= axis_d;
            grid_q   <= grid_d;
            ticks_q  <= ticks_d;
            fft_q    <= fft_d;
            amp_q    <= amp_d;
            btn_q    <= btn_d;
            idle_q   <= idle_d;
        end
    end

    always_comb begin
        btn_now  = {btn_right, btn_left, btn_select, btn_down, btn_up};
        ev       = btn_now & ~btn_q;
        btn_d    = btn_now;
        open_d   = open_q;
        page_d   = page_q;
        cursor_d = cursor_q;
        liro_d   = liro_q;
        wave_d   = wave_q;
        axis_d   = axis_q;
        grid_d   = grid_q;
        ticks_d  = ticks_q;
        fft_d    = fft_q;
        amp_d    = amp_q;
        idle_d   = idle_q;

        case (page_q)
            PG_MAIN: last_idx = 3'd2;
            PG_WAVE: last_idx = 3'd4;
            PG_DISP: last_idx = 3'd3;
            default: last_idx = 3'd2;
        endcase

        timeout_hit = (TIMEOUT_CYCLES != 32'd0) && open_q &&
                      (idle_q == TIMEOUT_CYCLES - 32'd1);

        if (clap_pulse) begin
            // Opening and closing both land on main page, cursor 0.
            open_d   = ~open_q;
            page_d   = PG_MAIN;
            cursor_d = 3'd0;
            idle_d   = 32'd0;
        end else if (!open_q) begin
            idle_d = 32'd0;
        end else begin
            idle_d = (|ev) ? 32'd0 : idle_q + 32'd1;

            if (ev[BI_LEFT] && !ev[BI_RIGHT])
                liro_d = liro_q - 2'd1;
            else if (ev[BI_RIGHT] && !ev[BI_LEFT])
                liro_d = liro_q + 2'd1;

            if (timeout_hit) begin
                open_d   = 1'b0;
                page_d   = PG_MAIN;
                cursor_d = 3'd0;
                idle_d   = 32'd0;
            end else if (ev[BI_SEL]) begin
                case (page_q)
                    PG_MAIN: begin
                        page_d   = page_e'(cursor_q[1:0] + 2'd1);
                        cursor_d = 3'd0;
                    end
                    PG_WAVE: begin
                        if (cursor_q == 3'd4) begin
                            page_d   = PG_MAIN;
                            cursor_d = 3'd0;
                        end else begin
                            wave_d = cursor_q[1:0];
                        end
                    end
                    PG_DISP: begin
                        case (cursor_q)
                            3'd0:    axis_d  = ~axis_q;
                            3'd1:    grid_d  = ~grid_q;
                            3'd2:    ticks_d = ~ticks_q;
                            default: begin
                                page_d   = PG_MAIN;
                                cursor_d = 3'd0;
                            end
                        endcase
                    end
                    default: begin
                        case (cursor_q)
                            3'd0:    fft_d = ~fft_q;
                            3'd1:    amp_d = ~amp_q;
                            default: begin
                                page_d   = PG_MAIN;
                                cursor_d = 3'd0;
                            end
                        endcase
                    end
                endcase
            end else if (ev[BI_UP] && !ev[BI_DOWN]) begin
                if (cursor_q != 3'd0)
                    cursor_d = cursor_q - 3'd1;
            end else if (ev[BI_DOWN] && !ev[BI_UP]) begin
                if (cursor_q < last_idx)
                    cursor_d = cursor_q + 3'd1;
            end
        end
    end

    assign Menu_Clap  = open_q;
    assign menu_state = page_q;
    assign cursor     = cursor_q;
    assign LIRO_state = liro_q;
    assign wave_sel   = wave_q;
    assign axis_en    = axis_q;
    assign grid_en    = grid_q;
    assign ticks_en   = ticks_q;
    assign fft_en     = fft_q;
    assign amp_en     = amp_q;

endmodule

`default_nettype wire

// File: tb/tb_imba_menu_controller.sv
// ============================================================================
// Module   : tb_imba_menu_controller
// Purpose  : Directed self-checking bench for imba_menu_controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_imba_menu_controller;

    localparam logic [4:0] B_UP = 5'b00001, B_DN = 5'b00010, B_SEL = 5'b00100,
                           B_LT = 5'b01000, B_RT = 5'b10000;

    logic       clk;
    logic       rst_n;
    logic       clap;
    logic [4:0] btn;

    logic       mc, ax, gr, tk, ff, am;
    logic [1:0] ms, lr, ws;
    logic [2:0] cu;

    logic       t_mc, t_ax, t_gr, t_tk, t_ff, t_am;
    logic [1:0] t_ms, t_lr, t_ws;
    logic [2:0] t_cu;

    int checks   = 0;
    int failures = 0;

    imba_menu_controller dut (
        .CLK_VGA(clk), .RST_N(rst_n), .clap_pulse(clap),
        .btn_up(btn[0]), .btn_down(btn[1]), .btn_select(btn[2]),
        .btn_left(btn[3]), .btn_right(btn[4]),
        .Menu_Clap(mc), .menu_state(ms), .cursor(cu), .LIRO_state(lr),
        .wave_sel(ws), .axis_en(ax), .grid_en(gr), .ticks_en(tk),
        .fft_en(ff), .amp_en(am)
    );

    imba_menu_controller #(.TIMEOUT_CYCLES(32'd10)) dut_t (
        .CLK_VGA(clk), .RST_N(rst_n), .clap_pulse(clap),
        .btn_up(btn[0]), .btn_down(btn[1]), .btn_select(btn[2]),
        .btn_left(btn[3]), .btn_right(btn[4]),
        .Menu_Clap(t_mc), .menu_state(t_ms), .cursor(t_cu), .LIRO_state(t_lr),
        .wave_sel(t_ws), .axis_en(t_ax), .grid_en(t_gr), .ticks_en(t_tk),
        .fft_en(t_ff), .amp_en(t_am)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] m);
        btn = m;
        tick();
        btn = 5'd0;
        tick();
    endtask

    task automatic do_clap();
        clap = 1'b1;
        tick();
        clap = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clap  = 1'b0;
        btn   = 5'd0;
        #12;
        check("rst_menu", mc, 0);
        check("rst_state", ms, 0);
        check("rst_cursor", cu, 0);
        check("rst_liro", lr, 0);
        check("rst_wave", ws, 0);
        check("rst_settings", {ax, gr, tk, ff, am}, 5'b10100);
        tick();
        rst_n = 1'b1;
        tick();

        // Open and navigate
        do_clap();
        check("open_menu", mc, 1);
        check("open_state", ms, 0);
        check("open_cursor", cu, 0);
        check("open_settings", {ax, gr, tk}, 3'b101);
        repeat (5) press(B_DN);
        check("down_sat", cu, 2);
        press(B_SEL);
        check("to_analysis", ms, 3);
        check("to_analysis_cur", cu, 0);
        press(B_SEL);
        check("fft_toggle", ff, 1);
        press(B_DN);
        press(B_DN);
        check("anal_cur2", cu, 2);
        press(B_SEL);
        check("anal_back", ms, 0);
        check("anal_back_cur", cu, 0);

        // Waveform page
        press(B_SEL);
        check("to_wave", ms, 1);
        repeat (3) press(B_DN);
        press(B_SEL);
        check("wave_sel3", ws, 3);
        check("wave_cur_kept", cu, 3);
        press(B_DN);
        press(B_SEL);
        check("wave_back", ms, 0);
        press(B_SEL);
        btn = B_DN;
        repeat (100) tick();
        btn = 5'd0;
        tick();
        check("hold_once", cu, 1);
        repeat (4) press(B_DN);
        check("wave_down_sat", cu, 4);
        press(B_SEL);
        check("wave_back2", ms, 0);

        // LIRO and same-cycle events
        press(B_LT);
        check("liro_wrap_dn", lr, 3);
        press(B_RT);
        press(B_RT);
        check("liro_wrap_up", lr, 1);
        press(B_LT | B_RT);
        check("liro_both", lr, 1);
        press(B_DN);
        press(B_UP | B_DN);
        check("updown_both", cu, 1);
        press(B_UP);
        check("up_dec", cu, 0);
        press(B_UP);
        check("up_sat", cu, 0);
        press(B_DN);
        clap = 1'b1;
        btn  = B_SEL;
        tick();
        clap = 1'b0;
        btn  = 5'd0;
        tick();
        check("clap_sel_close", mc, 0);
        check("clap_sel_state", ms, 0);
        check("clap_sel_cursor", cu, 0);
        check("clap_sel_settings", {ax, gr, tk, ff, am}, 5'b10110);
        check("liro_persist", lr, 1);

        // Closed menu ignores buttons
        press(B_SEL);
        press(B_DN);
        press(B_RT);
        check("closed_cursor", cu, 0);
        check("closed_liro", lr, 1);
        check("closed_state", ms, 0);

        // Display page, then async reset
        do_clap();
        press(B_DN);
        press(B_SEL);
        check("to_display", ms, 2);
        press(B_DN);
        press(B_SEL);
        check("grid_on", gr, 1);
        press(B_SEL);
        press(B_SEL);
        check("grid_toggle_twice", gr, 1);
        press(B_UP);
        press(B_SEL);
        check("axis_off", ax, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_menu", mc, 0);
        check("arst_state", ms, 0);
        check("arst_cursor", cu, 0);
        check("arst_liro", lr, 0);
        check("arst_settings", {ax, gr, tk, ff, am}, 5'b10100);
        check("arst_t_menu", t_mc, 0);
        btn = B_DN;
        tick();
        rst_n = 1'b1;
        tick();
        btn = 5'd0;
        tick();

        // Timeout instance (10 cycles)
        do_clap();
        check("to_open", t_mc, 1);
        repeat (9) tick();
        check("to_still_open", t_mc, 1);
        tick();
        check("to_closed", t_mc, 0);
        do_clap();
        repeat (7) tick();
        btn = B_SEL;
        tick();
        btn = 5'd0;
        check("to_sel_page", t_ms, 1);
        repeat (9) tick();
        check("to_restart_open", t_mc, 1);
        tick();
        check("to_restart_closed", t_mc, 0);
        check("to_close_state", t_ms, 0);
        repeat (3) tick();
        do_clap();
        check("to_reopen", t_mc, 1);
        check("to_reopen_state", t_ms, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imba_menu_controller.md
# imba_menu_controller

Sequential control stage directly upstream of the menu overlay renderer. It converts a clap pulse and debounced push-buttons into the registered menu visibility, page, cursor, LIRO selection and display/analysis settings. The renderer draws from `Menu_Clap`, `menu_state` and `LIRO_state`. The waveform, grid and analysis blocks consume the setting outputs.

## Interface
- `TIMEOUT_CYCLES`, default 32'd540_000_000 (5 s at 108 MHz): idle cycles before the menu auto-closes. 0 disables the timeout.
- `CLK_VGA`  in  1  pixel clock (108 MHz); all state changes on its rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `clap_pulse`  in  1  single-cycle pulse from the clap detector, synchronous to `CLK_VGA`.
- `btn_up`, `btn_down`, `btn_select`, `btn_left`, `btn_right`  in  1 each  debounced, synchronous, level-high buttons.
- `Menu_Clap`  out  1  menu visible.
- `menu_state`  out  2  page: 0 main, 1 waveform, 2 display, 3 analysis.
- `cursor`  out  3  highlighted item on the current page.
- `LIRO_state`  out  2  highlighted LIRO box, 0..3.
- `wave_sel`  out  2  0 default, 1 pulsar, 2 blocks, 3 none.
- `axis_en`, `grid_en`, `ticks_en`, `fft_en`, `amp_en`  out  1 each  feature enables.

## Operation
- Each button has a 1-register rising-edge detector. An event is `btn & ~btn_q`. Held buttons produce exactly one event.
- Item count N per page: main 3, waveform 5, display 4, analysis 3.
- Cursor moves only within the page:
  - up: cursor = max(cursor-1, 0).
  - down: cursor = min(cursor+1, N-1).
  - Saturating; no wrap.
- Select actions by page and cursor:
  - main k → `menu_state` = k+1, cursor = 0.
  - waveform 0..3 → `wave_sel` = cursor, page unchanged. Waveform 4 (Back) → `menu_state` = 0, cursor = 0.
  - display 0/1/2 → toggle `axis_en` / `grid_en` / `ticks_en`. Display 3 (Back) → main, cursor 0.
  - analysis 0/1 → toggle `fft_en` / `amp_en`. Analysis 2 (Back) → main, cursor 0.
- Select never moves the cursor, except on page changes.
- LIRO selection:
  - left: `LIRO_state` − 1 mod 4 (0 → 3).
  - right: `LIRO_state` + 1 mod 4 (3 → 0).
- `clap_pulse` toggles `Menu_Clap`:
  - Opening forces `menu_state` = 0 and cursor = 0.
  - Closing forces the same. `LIRO_state` and all settings persist.
- While `Menu_Clap` = 0, all button events are ignored; the edge registers still track.
- Idle counter (32 b):
  - Cleared by any clap or button event, and held at 0 while closed.
  - Otherwise increments while open.
  - On reaching `TIMEOUT_CYCLES` (nonzero), the menu closes exactly as for a clap, and the counter clears.
- Same-cycle priority:
  - Clap beats timeout beats select beats up/down.
  - up and down together → no cursor change.
  - left and right together → no LIRO change.
  - LIRO handling is independent of select and up/down; both apply in the same cycle.
  - A clap in the same cycle as other events discards them.

## Timing
- Reset (async assert, sync deassert by source) values:
  - `Menu_Clap` = 0, `menu_state` = 0, `cursor` = 0, `LIRO_state` = 0, `wave_sel` = 0.
  - `axis_en` = 1, `grid_en` = 0, `ticks_en` = 1, `fft_en` = 0, `amp_en` = 0.
  - Edge registers = 0, idle counter = 0.
- All outputs are registered; no combinational input→output paths.
- Latency:
  - Button high is first sampled at edge E, with `btn_q` = 0. The output changes after E; registers update at E.
  - `clap_pulse` high at edge E → `Menu_Clap` toggled after E.
- Timeout: the counter reaches `TIMEOUT_CYCLES` on the edge after `TIMEOUT_CYCLES` idle edges; `Menu_Clap` falls on that edge.
- Reset mid-operation returns every output to its reset value immediately, independent of `CLK_VGA`.
- A button already held high when reset releases produces no event, because the edge register loads the live level on the first post-reset edge and so sees no rising edge.

## Test plan
- Reset, then clap pulse: `Menu_Clap` 0→1 after one edge, with `menu_state` = 0 and cursor = 0. Settings keep their reset values (axis 1, grid 0, ticks 1).
- Navigation:
  - Open; down ×5 → cursor 2 (saturated).
  - Select → `menu_state` = 3, cursor 0.
  - Select → `fft_en` = 1.
  - Down, down, select → `menu_state` = 0.
- Waveform page:
  - Open; select (page 1); down ×3; select → `wave_sel` = 3.
  - Down, select → main.
  - Holding `btn_down` for 100 cycles moves the cursor by 1 only.
- LIRO and same-cycle events:
  - Open; left → `LIRO_state` = 3; right ×2 → 1.
  - `btn_up` and `btn_down` asserted in the same cycle → cursor unchanged.
  - Clap and select in the same cycle → menu closes, no toggle.
- Timeout with `TIMEOUT_CYCLES` = 10:
  - Open, no input → `Menu_Clap` falls 10 edges later.
  - A button event at cycle 8 restarts the count.
  - A clap while closed reopens at page 0.
- Async reset mid-operation: `RST_N` low at an arbitrary phase while on page 2 with `grid_en` = 1 → all outputs take their reset values before the next `CLK_VGA` edge. Button presses while the menu is closed change nothing.
